// File: rtl/coh_noc_pkg.sv
// Shared CoH NoC definitions: transaction-monitor state encoding, register map
// and CTRL/STATUS bit positions.
package coh_noc_pkg;

  typedef enum logic [1:0] {
    TXN_MON_STOPPED = 2'd0,
    TXN_MON_RUNNING = 2'd1,
    TXN_MON_FROZEN  = 2'd2
  } txn_mon_state_e;

  localparam int TXN_MON_CTRL_ADDR        = 'h000;
  localparam int TXN_MON_STATUS_ADDR      = 'h001;
  localparam int TXN_MON_TOTAL_ADDR       = 'h002;
  localparam int TXN_MON_ACTIVE_ADDR      = 'h003;
  localparam int TXN_MON_HWM_ADDR         = 'h004;
  localparam int TXN_MON_LAT_SUM_ADDR     = 'h005;
  localparam int TXN_MON_PORT_TOTAL_BASE  = 'h100;
  localparam int TXN_MON_PORT_OUTST_BASE  = 'h200;

  localparam int TXN_MON_CTRL_ENABLE_BIT  = 0;
  localparam int TXN_MON_CTRL_CLEAR_BIT   = 1;
  localparam int TXN_MON_CTRL_FREEZE_BIT  = 2;
  localparam int TXN_MON_STATUS_OVF_BIT   = 8;
  localparam int TXN_MON_STATUS_UDF_BIT   = 9;

endpackage

// File: rtl/coh_noc_txn_port_ctr.sv
// Per-port outstanding counter and request total; decides which fires are
// accepted and flags saturation/underflow events.
module coh_noc_txn_port_ctr #(
  parameter int OUTST_W = 8,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req,
  input  logic               rsp,
  input  logic               stat_en,
  input  logic               clear,
  output logic               accepted_req,
  output logic               accepted_rsp,
  output logic               ovf,
  output logic               udf,
  output logic [OUTST_W-1:0] outst,
  output logic [CNT_W-1:0]   port_total
);

  logic full, empty, pt_sat;

  assign full  = &outst;
  assign empty = (outst == '0);

  // A simultaneous req/rsp pair nets to zero, so it is always accepted.
  assign accepted_req = req && (rsp || !full);
  assign accepted_rsp = rsp && (req || !empty);

  assign pt_sat = stat_en && accepted_req && (&port_total);
  assign ovf    = (req && !rsp && full) || pt_sat;
  assign udf    = rsp && !req && empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      outst      <= '0;
      port_total <= '0;
    end else begin
      if (accepted_req && !accepted_rsp)      outst <= outst + 1'b1;
      else if (accepted_rsp && !accepted_req) outst <= outst - 1'b1;
      if (clear)                              port_total <= '0;
      else if (stat_en && accepted_req && !pt_sat) port_total <= port_total + 1'b1;
    end
  end

endmodule

// File: rtl/coh_noc_txn_monitor.sv
// NoC transaction monitor: per-port/aggregate outstanding tracking plus
// run/freeze statistics behind the cfg register bus. COH_NOC_TXN_LAT_EN adds LAT_SUM.
module coh_noc_txn_monitor
  import coh_noc_pkg::*;
#(
  parameter int NUM_PORTS = 16,
  parameter int CNT_W     = 32,
  parameter int OUTST_W   = 8,
  parameter int ADDR_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req_fire,
  input  logic [NUM_PORTS-1:0] rsp_fire,
  input  logic                 cfg_write,
  input  logic                 cfg_read,
  input  logic [ADDR_W-1:0]    cfg_addr,
  input  logic [31:0]          cfg_wdata,
  output logic [31:0]          cfg_rdata,
  output logic                 cfg_ready,
  output logic [CNT_W-1:0]     active_transactions,
  output logic                 mon_running,
  output logic                 mon_error
);

  localparam int AW  = OUTST_W + $clog2(NUM_PORTS);
  localparam int PCW = $clog2(NUM_PORTS + 1);
  localparam int TW  = CNT_W + PCW;

  logic [NUM_PORTS-1:0]              acc_req, acc_rsp, p_ovf, p_udf;
  logic [NUM_PORTS-1:0][OUTST_W-1:0] p_outst;
  logic [NUM_PORTS-1:0][CNT_W-1:0]   p_total;

  txn_mon_state_e   state_q, state_d;
  logic             enable_q, freeze_q, ovf_q, udf_q, ovf_d, udf_d;
  logic             wr_ctrl, wr_status, clr, stat_en, running_d;
  logic [PCW-1:0]   n_req, n_rsp;
  logic [AW-1:0]    active_q, active_d, hwm_q;
  logic [CNT_W-1:0] total_q, lat_rd;
  logic [TW-1:0]    tot_sum;
  logic             tot_ovf, lat_ovf;
  logic [31:0]      rd_val;
  logic             unused_wdata;

  assign unused_wdata = ^{cfg_wdata[31:10], cfg_wdata[7:3]};

  assign wr_ctrl   = cfg_write && (cfg_addr == ADDR_W'(TXN_MON_CTRL_ADDR));
  assign wr_status = cfg_write && (cfg_addr == ADDR_W'(TXN_MON_STATUS_ADDR));
  assign clr       = wr_ctrl && cfg_wdata[TXN_MON_CTRL_CLEAR_BIT];
  // Stat increments landing in the clear cycle are dropped.
  assign stat_en   = (state_q == TXN_MON_RUNNING) && !clr;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    coh_noc_txn_port_ctr #(.OUTST_W(OUTST_W), .CNT_W(CNT_W)) u_port (
      .clk          (clk),
      .rst          (rst),
      .req          (req_fire[p]),
      .rsp          (rsp_fire[p]),
      .stat_en      (stat_en),
      .clear        (clr),
      .accepted_req (acc_req[p]),
      .accepted_rsp (acc_rsp[p]),
      .ovf          (p_ovf[p]),
      .udf          (p_udf[p]),
      .outst        (p_outst[p]),
      .port_total   (p_total[p])
    );
  end

  always_comb begin
    n_req = '0;
    n_rsp = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      n_req = n_req + PCW'(acc_req[p]);
      n_rsp = n_rsp + PCW'(acc_rsp[p]);
    end
  end

  assign active_d = active_q + AW'(n_req) - AW'(n_rsp);
  assign tot_sum  = TW'(total_q) + TW'(n_req);
  assign tot_ovf  = stat_en && (tot_sum[TW-1:CNT_W] != '0);

`ifdef COH_NOC_TXN_LAT_EN
  logic [CNT_W-1:0]    lat_q;
  logic [CNT_W+AW-1:0] lat_sum;
  assign lat_sum = (CNT_W+AW)'(lat_q) + (CNT_W+AW)'(active_q);
  assign lat_ovf = stat_en && (lat_sum[CNT_W+AW-1:CNT_W] != '0);
  assign lat_rd  = lat_q;
  always_ff @(posedge clk) begin
    if (rst || clr)   lat_q <= '0;
    else if (stat_en) lat_q <= lat_ovf ? '1 : lat_sum[CNT_W-1:0];
  end
`else
  assign lat_ovf = 1'b0;
  assign lat_rd  = '0;
`endif

  // Event flags set after W1C so a same-cycle event is never lost; clear wins.
  assign ovf_d = clr ? 1'b0
               : (ovf_q && !(wr_status && cfg_wdata[TXN_MON_STATUS_OVF_BIT])) || (|p_ovf) || tot_ovf || lat_ovf;
  assign udf_d = clr ? 1'b0
               : (udf_q && !(wr_status && cfg_wdata[TXN_MON_STATUS_UDF_BIT])) || (|p_udf);

  always_ff @(posedge clk) begin
    if (rst) state_q <= TXN_MON_STOPPED;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TXN_MON_STOPPED:
        if (wr_ctrl && cfg_wdata[TXN_MON_CTRL_ENABLE_BIT]) state_d = TXN_MON_RUNNING;
      TXN_MON_RUNNING:
        if (wr_ctrl && !cfg_wdata[TXN_MON_CTRL_ENABLE_BIT]) state_d = TXN_MON_STOPPED;
        else if (freeze_q && ovf_d)                          state_d = TXN_MON_FROZEN;
      TXN_MON_FROZEN:
        if (wr_ctrl && !cfg_wdata[TXN_MON_CTRL_ENABLE_BIT])  state_d = TXN_MON_STOPPED;
        else if (clr && cfg_wdata[TXN_MON_CTRL_ENABLE_BIT])  state_d = TXN_MON_RUNNING;
      default: state_d = TXN_MON_STOPPED;
    endcase
  end

  always_comb begin
    running_d = (state_d == TXN_MON_RUNNING);
  end

  always_comb begin
    rd_val = '0;
    if (cfg_addr == ADDR_W'(TXN_MON_CTRL_ADDR)) begin
      rd_val[TXN_MON_CTRL_ENABLE_BIT] = enable_q;
      rd_val[TXN_MON_CTRL_FREEZE_BIT] = freeze_q;
    end else if (cfg_addr == ADDR_W'(TXN_MON_STATUS_ADDR)) begin
      rd_val[1:0]                    = state_q;
      rd_val[TXN_MON_STATUS_OVF_BIT] = ovf_q;
      rd_val[TXN_MON_STATUS_UDF_BIT] = udf_q;
    end else if (cfg_addr == ADDR_W'(TXN_MON_TOTAL_ADDR))   rd_val = 32'(total_q);
    else if (cfg_addr == ADDR_W'(TXN_MON_ACTIVE_ADDR))      rd_val = 32'(active_q);
    else if (cfg_addr == ADDR_W'(TXN_MON_HWM_ADDR))         rd_val = 32'(hwm_q);
    else if (cfg_addr == ADDR_W'(TXN_MON_LAT_SUM_ADDR))     rd_val = 32'(lat_rd);
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (cfg_addr == ADDR_W'(TXN_MON_PORT_TOTAL_BASE + p)) rd_val = 32'(p_total[p]);
      if (cfg_addr == ADDR_W'(TXN_MON_PORT_OUTST_BASE + p)) rd_val = 32'(p_outst[p]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enable_q    <= 1'b0;
      freeze_q    <= 1'b0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
      active_q    <= '0;
      hwm_q       <= '0;
      total_q     <= '0;
      cfg_rdata   <= '0;
      cfg_ready   <= 1'b0;
      mon_running <= 1'b0;
      mon_error   <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        enable_q <= cfg_wdata[TXN_MON_CTRL_ENABLE_BIT];
        freeze_q <= cfg_wdata[TXN_MON_CTRL_FREEZE_BIT];
      end
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      active_q <= active_d;
      if (clr) begin
        total_q <= '0;
        hwm_q   <= '0;
      end else if (stat_en) begin
        total_q <= tot_ovf ? '1 : tot_sum[CNT_W-1:0];
        if (active_d > hwm_q) hwm_q <= active_d;
      end
      if (cfg_read && !cfg_write) cfg_rdata <= rd_val;
      cfg_ready   <= cfg_read || cfg_write;
      mon_running <= running_d;
      mon_error   <= ovf_d || udf_d;
    end
  end

  assign active_transactions = CNT_W'(active_q);

endmodule

// File: tb/tb_coh_noc_txn_monitor.sv
// Directed scoreboard bench for coh_noc_txn_monitor (16 ports, 2-bit outstanding).
module tb_coh_noc_txn_monitor;

  localparam int NP = 16;
  localparam int CW = 32;
  localparam int OW = 2;
  localparam int AD = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NP-1:0] req_fire = '0;
  logic [NP-1:0] rsp_fire = '0;
  logic          cfg_write = 1'b0;
  logic          cfg_read = 1'b0;
  logic [AD-1:0] cfg_addr = '0;
  logic [31:0]   cfg_wdata = '0;
  logic [31:0]   cfg_rdata;
  logic          cfg_ready;
  logic [CW-1:0] active_transactions;
  logic          mon_running;
  logic          mon_error;

  coh_noc_txn_monitor #(.NUM_PORTS(NP), .CNT_W(CW), .OUTST_W(OW), .ADDR_W(AD)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .req_fire            (req_fire),
    .rsp_fire            (rsp_fire),
    .cfg_write           (cfg_write),
    .cfg_read            (cfg_read),
    .cfg_addr            (cfg_addr),
    .cfg_wdata           (cfg_wdata),
    .cfg_rdata           (cfg_rdata),
    .cfg_ready           (cfg_ready),
    .active_transactions (active_transactions),
    .mon_running         (mon_running),
    .mon_error           (mon_error)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  string       nm_q[$];
  logic [31:0] last_rd = '0;
  logic [31:0] mon_exp;
  string       mon_nm;

  // Every cfg_ready pulse consumes one expected entry; writes expect rdata held.
  always @(negedge clk) begin
    if (cfg_ready) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_ready: rdata=%h, no access pending", cfg_rdata);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_nm  = nm_q.pop_front();
        if (cfg_rdata !== mon_exp) begin
          n_err++;
          $display("FAIL %s: got %h expected %h", mon_nm, cfg_rdata, mon_exp);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic rd(input logic [AD-1:0] a, input logic [31:0] e, input string nm);
    cfg_addr = a;
    cfg_read = 1'b1;
    exp_q.push_back(e);
    nm_q.push_back(nm);
    last_rd = e;
    cyc();
    cfg_read = 1'b0;
  endtask

  task automatic wr(input logic [AD-1:0] a, input logic [31:0] d, input string nm);
    cfg_addr  = a;
    cfg_wdata = d;
    cfg_write = 1'b1;
    exp_q.push_back(last_rd);
    nm_q.push_back(nm);
    cyc();
    cfg_write = 1'b0;
  endtask

  task automatic fire(input logic [NP-1:0] r, input logic [NP-1:0] s, input int n);
    req_fire = r;
    rsp_fire = s;
    repeat (n) cyc();
    req_fire = '0;
    rsp_fire = '0;
  endtask

  initial begin
    repeat (3) cyc();
    chk("rst_rdata", cfg_rdata, 32'h0);
    chk("rst_ready", 32'(cfg_ready), 32'h0);
    chk("rst_active", active_transactions, 32'h0);
    chk("rst_running", 32'(mon_running), 32'h0);
    chk("rst_error", 32'(mon_error), 32'h0);
    rst = 1'b0;
    cyc();
    rd(16'h001, 32'h0, "status_reset");

    // Aggregate counting
    wr(16'h000, 32'h1, "wr_enable");
    chk("running_after_enable", 32'(mon_running), 32'h1);
    fire(16'hFFFF, 16'h0000, 1);
    chk("active_16", active_transactions, 32'd16);
    rd(16'h002, 32'd16, "total_16");
    rd(16'h003, 32'd16, "active_16_reg");
    rd(16'h004, 32'd16, "hwm_16");
    fire(16'h0000, 16'h00FF, 1);
    rd(16'h003, 32'd8, "active_8");
    rd(16'h004, 32'd16, "hwm_holds");
    rd(16'h200, 32'd0, "outst0_zero");
    rd(16'h208, 32'd1, "outst8_one");
    rd(16'h105, 32'd1, "ptotal5");

    // Same-cycle req and rsp
    fire(16'h0008, 16'h0000, 2);
    fire(16'h0008, 16'h0008, 5);
    rd(16'h203, 32'd2, "outst3_net0");
    rd(16'h103, 32'd8, "ptotal3_plus5");
    rd(16'h002, 32'd23, "total_23");
    rd(16'h001, 32'h001, "status_noflags");
    chk("error_none", 32'(mon_error), 32'h0);

    // Underflow and W1C
    fire(16'h0000, 16'h0001, 1);
    chk("error_udf", 32'(mon_error), 32'h1);
    chk("active_udf_hold", active_transactions, 32'd10);
    rd(16'h001, 32'h201, "status_udf");
    wr(16'h001, 32'h200, "w1c_udf");
    chk("error_cleared", 32'(mon_error), 32'h0);
    rd(16'h001, 32'h001, "status_udf_cleared");

    // Read sampled in the same cycle as a TOTAL increment
    cfg_addr = 16'h002;
    cfg_read = 1'b1;
    req_fire = 16'h0010;
    exp_q.push_back(32'd23);
    nm_q.push_back("total_pre_incr");
    last_rd = 32'd23;
    cyc();
    cfg_read = 1'b0;
    req_fire = '0;
    rd(16'h002, 32'd24, "total_post_incr");

    // Simultaneous read and write: one ready, rdata held, write applied
    cfg_addr  = 16'h000;
    cfg_wdata = 32'h5;
    cfg_read  = 1'b1;
    cfg_write = 1'b1;
    exp_q.push_back(last_rd);
    nm_q.push_back("rw_rdata_held");
    cyc();
    cfg_read  = 1'b0;
    cfg_write = 1'b0;
    cyc();
    rd(16'h000, 32'h5, "ctrl_written");

    // Outstanding saturation with freeze
    fire(16'h0001, 16'h0000, 4);
    chk("frozen_not_running", 32'(mon_running), 32'h0);
    chk("error_ovf", 32'(mon_error), 32'h1);
    rd(16'h200, 32'd3, "outst0_sat");
    rd(16'h001, 32'h102, "status_frozen_ovf");
    rd(16'h002, 32'd27, "total_27");
    fire(16'h0003, 16'h0000, 2);
    rd(16'h002, 32'd27, "total_frozen");
    rd(16'h101, 32'd1, "ptotal1_frozen");
    rd(16'h201, 32'd2, "outst1_frozen");
    rd(16'h003, 32'd16, "active_frozen");
    wr(16'h000, 32'h7, "clear_enable");
    chk("running_after_clear", 32'(mon_running), 32'h1);
    chk("error_after_clear", 32'(mon_error), 32'h0);
    rd(16'h004, 32'd0, "hwm_cleared");
    rd(16'h002, 32'd0, "total_cleared");
    rd(16'h004, 32'd16, "hwm_regrow");
    rd(16'h200, 32'd3, "outst0_kept");
    rd(16'h103, 32'd0, "ptotal3_cleared");
    rd(16'h001, 32'h001, "status_running");
    rd(16'h000, 32'h5, "ctrl_clear_reads0");
    rd(16'h005, 32'd0, "lat_sum_absent");
    rd(16'h110, 32'd0, "ptotal_oob");
    rd(16'h006, 32'd0, "unmapped");

    // Stopped: outstanding tracked, stats not
    wr(16'h000, 32'h0, "disable");
    chk("stopped", 32'(mon_running), 32'h0);
    fire(16'h0000, 16'h0002, 1);
    fire(16'h0004, 16'h0000, 1);
    rd(16'h003, 32'd16, "active_stopped");
    rd(16'h002, 32'd0, "total_stopped");
    rd(16'h102, 32'd0, "ptotal2_stopped");
    rd(16'h202, 32'd1, "outst2_stopped");
    rd(16'h201, 32'd1, "outst1_stopped");

    // Reset mid-operation drops the pending read
    rst = 1'b1;
    cfg_addr = 16'h003;
    cfg_read = 1'b1;
    cyc();
    cfg_read = 1'b0;
    cyc();
    rst = 1'b0;
    last_rd = '0;
    chk("midrst_active", active_transactions, 32'h0);
    chk("midrst_running", 32'(mon_running), 32'h0);
    rd(16'h003, 32'd0, "active_after_rst");
    rd(16'h200, 32'd0, "outst0_after_rst");
    rd(16'h001, 32'h0, "status_after_rst");

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) cyc();
    cyc();
    n_chk++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d accesses never completed, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
